// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the EX stage.
// Holds the pipeline through stall_o while iterating, then emits one writeback beat.
module ex_muldiv #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 6
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  start_i,
   input  logic [2:0]            op_i,
   input  logic [XLEN-1:0]       op1_i,
   input  logic [XLEN-1:0]       op2_i,
   input  logic [REG_ADDR_W-1:0] reg_w_addr_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic                  reg_w_ena_o,
   output logic [REG_ADDR_W-1:0] reg_w_addr_o,
   output logic [XLEN-1:0]       reg_w_data_o
);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [2*XLEN-1:0]       acc_q;
   logic [2*XLEN-1:0]       acc_d;
   logic [XLEN-1:0]         b_q;
   logic [2:0]              op_q;
   logic                    a_neg_q;
   logic                    b_neg_q;
   logic [REG_ADDR_W-1:0]   addr_q;
   logic                    ena_q;
   logic [XLEN-1:0]         data_q;
   logic [XLEN-1:0]         data_d;

   logic                    a_signed;
   logic                    b_signed;
   logic                    a_neg;
   logic                    b_neg;
   logic                    div_zero;
   logic                    div_ovf;
   logic                    special;
   logic [XLEN-1:0]         a_mag;
   logic [XLEN-1:0]         b_mag;
   logic [XLEN-1:0]         spec_res;

   logic [XLEN:0]           mul_sum;
   logic [XLEN:0]           div_sh;
   logic [XLEN:0]           div_diff;
   logic [2*XLEN-1:0]       prod;
   logic [XLEN-1:0]         quo;
   logic [XLEN-1:0]         rem;

   // Start-cycle decode: operand magnitudes, signs and the early-out cases.
   always_comb begin
      a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
      b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
      a_neg    = a_signed && op1_i[XLEN-1];
      b_neg    = b_signed && op2_i[XLEN-1];
      a_mag    = a_neg ? -op1_i : op1_i;
      b_mag    = b_neg ? -op2_i : op2_i;
      div_zero = op_i[2] && (op2_i == '0);
      div_ovf  = op_i[2] && !op_i[0] && (op1_i == MIN_NEG) && (op2_i == '1);
      special  = div_zero || div_ovf;
      if (div_zero) begin
         spec_res = op_i[1] ? op1_i : '1;
      end else begin
         spec_res = op_i[1] ? '0 : op1_i;
      end
   end

   // acc_q is {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff = div_sh - {1'b0, b_q};
      if (op_q[2]) begin
         acc_d = {(div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0]),
                  acc_q[XLEN-2:0], ~div_diff[XLEN]};
      end else begin
         acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
      prod = (a_neg_q ^ b_neg_q) ? -acc_d : acc_d;
      quo  = acc_d[XLEN-1:0];
      rem  = acc_d[2*XLEN-1:XLEN];
      if (!op_q[2]) begin
         data_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end else if (op_q[1]) begin
         data_d = a_neg_q ? -rem : rem;
      end else begin
         data_d = (a_neg_q ^ b_neg_q) ? -quo : quo;
      end
   end

   // start_i is the valid; stall_o low means the instruction in EX is accepted/retired this cycle.
   assign stall_o      = ((state_q == IDLE) && start_i && !flush_i) || (state_q == CALC);
   assign reg_w_ena_o  = ena_q && !flush_i;
   assign reg_w_addr_o = addr_q;
   assign reg_w_data_o = data_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         b_q     <= '0;
         op_q    <= '0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         addr_q  <= '0;
         ena_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         ena_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i && !flush_i) begin
                  op_q    <= op_i;
                  addr_q  <= reg_w_addr_i;
                  a_neg_q <= a_neg;
                  b_neg_q <= b_neg;
                  acc_q   <= {{XLEN{1'b0}}, a_mag};
                  b_q     <= b_mag;
                  cnt_q   <= '0;
                  if (special) begin
                     state_q <= DONE;
                     ena_q   <= 1'b1;
                     data_q  <= spec_res;
                  end else begin
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               if (flush_i) begin
                  state_q <= IDLE;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_LAST) begin
                     state_q <= DONE;
                     ena_q   <= 1'b1;
                     data_q  <= data_d;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: XLEN=32 instance for most scenarios, XLEN=64 for wide multiply.
// Expected results are queued at issue and popped when the writeback strobe appears.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        arst_n;
   always #5 clk = ~clk;

   logic        start_i, flush_i;
   logic [2:0]  op_i;
   logic [31:0] op1_i, op2_i;
   logic [4:0]  rd_i;
   logic        stall_o, ena_o;
   logic [4:0]  addr_o;
   logic [31:0] data_o;

   logic        start64_i, flush64_i;
   logic [2:0]  op64_i;
   logic [63:0] a64_i, b64_i;
   logic [4:0]  rd64_i;
   logic        stall64_o, ena64_o;
   logic [4:0]  addr64_o;
   logic [63:0] data64_o;

   logic [63:0] exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   ex_muldiv #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(6)) dut32 (
      .clk(clk), .arst_n(arst_n), .start_i(start_i), .op_i(op_i),
      .op1_i(op1_i), .op2_i(op2_i), .reg_w_addr_i(rd_i), .flush_i(flush_i),
      .stall_o(stall_o), .reg_w_ena_o(ena_o), .reg_w_addr_o(addr_o), .reg_w_data_o(data_o)
   );

   ex_muldiv #(.XLEN(64), .REG_ADDR_W(5), .CNT_W(7)) dut64 (
      .clk(clk), .arst_n(arst_n), .start_i(start64_i), .op_i(op64_i),
      .op1_i(a64_i), .op2_i(b64_i), .reg_w_addr_i(rd64_i), .flush_i(flush64_i),
      .stall_o(stall64_o), .reg_w_ena_o(ena64_o), .reg_w_addr_o(addr64_o), .reg_w_data_o(data64_o)
   );

   // Reference model built on 64-bit signed/unsigned arithmetic.
   function automatic logic [31:0] ref32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, sp;
      logic [63:0]        ua, ub, up;
      logic [31:0]        r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = '0;
      case (op)
         3'd0: begin up = ua * ub; r = up[31:0]; end
         3'd1: begin sp = sa * sb; r = sp[63:32]; end
         3'd2: begin sp = sa * $signed(ub); r = sp[63:32]; end
         3'd3: begin up = ua * ub; r = up[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else begin sp = sa / sb; r = sp[31:0]; end
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else begin sp = sa % sb; r = sp[31:0]; end
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Issues one instruction (start_i held while stalled) and checks result, address, latency, stall length.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
      int          lat, stalls, exp_lat;
      bit          seen;
      logic [63:0] e;
      exp_lat = is_special(op, a, b) ? 1 : 33;
      exp_q.push_back({32'd0, exp});
      start_i = 1'b1; flush_i = 1'b0; op_i = op; op1_i = a; op2_i = b; rd_i = rd;
      lat = 0; stalls = 0; seen = 1'b0;
      while (!seen && lat <= 100) begin
         @(negedge clk);
         if (stall_o) stalls++;
         if (ena_o) begin
            seen = 1'b1;
            e = exp_q.pop_front();
            n_cmp++;
            if (data_o !== e[31:0]) begin
               n_err++; $display("FAIL %s data: got %h expected %h", name, data_o, e[31:0]);
            end
            n_cmp++;
            if (addr_o !== rd) begin
               n_err++; $display("FAIL %s addr: got %0d expected %0d", name, addr_o, rd);
            end
            n_cmp++;
            if (lat != exp_lat) begin
               n_err++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
            end
            n_cmp++;
            if (stalls != exp_lat) begin
               n_err++; $display("FAIL %s stall cycles: got %0d expected %0d", name, stalls, exp_lat);
            end
         end
         @(posedge clk); #1;
         lat++;
      end
      if (!seen) begin
         n_cmp++; n_err++;
         e = exp_q.pop_front();
         $display("FAIL %s timeout: no writeback, expected %h", name, e[31:0]);
      end
   endtask

   task automatic idle_check(input string name, input logic [31:0] exp_data);
      start_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ena_o !== 1'b0 || stall_o !== 1'b0) begin
         n_err++; $display("FAIL %s idle: got ena=%b stall=%b expected 0 0", name, ena_o, stall_o);
      end
      n_cmp++;
      if (data_o !== exp_data) begin
         n_err++; $display("FAIL %s hold: got %h expected %h", name, data_o, exp_data);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      start_i = 0; flush_i = 0; op_i = 0; op1_i = 0; op2_i = 0; rd_i = 0;
      start64_i = 0; flush64_i = 0; op64_i = 0; a64_i = 0; b64_i = 0; rd64_i = 0;
      #2;
      n_cmp++;
      if ({ena_o, stall_o, addr_o, data_o} !== '0) begin
         n_err++; $display("FAIL reset_active: got ena=%b stall=%b addr=%0d data=%h expected all 0",
                           ena_o, stall_o, addr_o, data_o);
      end
      repeat (2) @(posedge clk);
      #1 arst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({ena_o, stall_o, addr_o, data_o} !== '0) begin
         n_err++; $display("FAIL reset_release: got ena=%b stall=%b addr=%0d data=%h expected all 0",
                           ena_o, stall_o, addr_o, data_o);
      end
      n_cmp++;
      if ({ena64_o, stall64_o, addr64_o, data64_o} !== '0) begin
         n_err++; $display("FAIL reset_64: got ena=%b data=%h expected 0", ena64_o, data64_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB);
      idle_check("mul_one_beat", 32'hFFFF_FFEB);
      run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000);
      run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE);
      run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF);
      idle_check("mul_end", 32'hFFFF_FFFF);
   endtask

   task automatic test_div();
      run_op("div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD);
      run_op("rem_-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF);
      run_op("divu_100/7", 3'd5, 32'd100, 32'd7, 5'd9, 32'd14);
      run_op("remu_100/7", 3'd7, 32'd100, 32'd7, 5'd10, 32'd2);
      idle_check("div_end", 32'd2);
   endtask

   task automatic test_special();
      run_op("divu_by0", 3'd5, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF);
      run_op("rem_by0", 3'd6, 32'd5, 32'd0, 5'd12, 32'd5);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0);
      idle_check("special_end", 32'd0);
   endtask

   task automatic test_back_to_back();
      logic [2:0]  op;
      logic [31:0] a, b, r;
      r = '0;
      for (int i = 0; i < 12; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         r  = ref32(op, a, b);
         run_op($sformatf("b2b_%0d_op%0d", i, op), op, a, b, 5'(i + 16), r);
      end
      idle_check("b2b_end", r);
   endtask

   task automatic test_flush();
      int hits;
      start_i = 1'b1; flush_i = 1'b0; op_i = 3'd4; op1_i = 32'd1000; op2_i = 32'd3; rd_i = 5'd20;
      repeat (11) @(posedge clk);
      #1 flush_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ena_o !== 1'b0) begin
         n_err++; $display("FAIL flush_calc ena: got %b expected 0", ena_o);
      end
      @(posedge clk); #1;
      flush_i = 1'b0;
      run_op("flush_then_start", 3'd5, 32'd1000, 32'd3, 5'd21, 32'd333);
      idle_check("flush_then_start_end", 32'd333);

      start_i = 1'b1; flush_i = 1'b1; op_i = 3'd5; op1_i = 32'd50; op2_i = 32'd5; rd_i = 5'd22;
      @(negedge clk);
      n_cmp++;
      if (stall_o !== 1'b0) begin
         n_err++; $display("FAIL flush_start stall: got %b expected 0", stall_o);
      end
      @(posedge clk); #1;
      start_i = 1'b0; flush_i = 1'b0;
      hits = 0;
      repeat (40) begin
         @(negedge clk);
         if (ena_o || stall_o) hits++;
      end
      n_cmp++;
      if (hits != 0) begin
         n_err++; $display("FAIL flush_start activity: got %0d busy cycles expected 0", hits);
      end
      @(posedge clk); #1;

      start_i = 1'b1; op_i = 3'd5; op1_i = 32'd5; op2_i = 32'd0; rd_i = 5'd23;
      @(posedge clk); #1;
      flush_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ena_o !== 1'b0) begin
         n_err++; $display("FAIL flush_done ena: got %b expected 0", ena_o);
      end
      @(posedge clk); #1;
      start_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ena_o !== 1'b0 || stall_o !== 1'b0) begin
         n_err++; $display("FAIL flush_done after: got ena=%b stall=%b expected 0 0", ena_o, stall_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      start_i = 1'b1; flush_i = 1'b0; op_i = 3'd0; op1_i = 32'd12345; op2_i = 32'd678; rd_i = 5'd24;
      repeat (10) @(posedge clk);
      #3;
      arst_n = 1'b0;
      start_i = 1'b0;
      #1;
      n_cmp++;
      if ({ena_o, stall_o, addr_o, data_o} !== '0) begin
         n_err++; $display("FAIL reset_mid: got ena=%b stall=%b addr=%0d data=%h expected all 0",
                           ena_o, stall_o, addr_o, data_o);
      end
      @(posedge clk); #1;
      arst_n = 1'b1;
      run_op("after_reset_mul", 3'd0, 32'd12345, 32'd678, 5'd25, 32'd8369910);
      idle_check("after_reset_end", 32'd8369910);
   endtask

   task automatic run_op64(input string name, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp);
      int          lat;
      bit          seen;
      logic [63:0] e;
      exp_q.push_back(exp);
      start64_i = 1'b1; flush64_i = 1'b0; op64_i = op; a64_i = a; b64_i = b; rd64_i = rd;
      lat = 0; seen = 1'b0;
      while (!seen && lat <= 150) begin
         @(negedge clk);
         if (ena64_o) begin
            seen = 1'b1;
            e = exp_q.pop_front();
            n_cmp++;
            if (data64_o !== e) begin
               n_err++; $display("FAIL %s data: got %h expected %h", name, data64_o, e);
            end
            n_cmp++;
            if (lat != 65 || addr64_o !== rd) begin
               n_err++; $display("FAIL %s latency/addr: got %0d/%0d expected 65/%0d", name, lat, addr64_o, rd);
            end
         end
         @(posedge clk); #1;
         lat++;
      end
      if (!seen) begin
         n_cmp++; n_err++;
         e = exp_q.pop_front();
         $display("FAIL %s timeout: no writeback, expected %h", name, e);
      end
   endtask

   task automatic test_xlen64();
      run_op64("x64_mul", 3'd0, 64'h1_0000_0000, 64'h1_0000_0000, 5'd26, 64'd0);
      run_op64("x64_mulhu", 3'd3, 64'h1_0000_0000, 64'h1_0000_0000, 5'd27, 64'd1);
      run_op64("x64_mulh_neg", 3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3, 5'd28, 64'hFFFF_FFFF_FFFF_FFFF);
      start64_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_xlen64();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised multi-cycle execute unit for the RV32M/RV64M multiply/divide group (funct3 0–7).
- Sits beside the single-cycle ALU in the EX stage and receives decoded operands and the writeback address from id.
- Holds the pipeline through a stall request to ctrl while iterating, then presents one writeback beat to mem.
- Supersedes the combinational-only EX path for M-extension instructions; operand width is generic.

Parameters:
- XLEN, 32, operand/result width in bits (32 or 64).
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- start_i  in  1  valid M-extension instruction present in EX this cycle.
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op1_i  in  XLEN  rs1 value.
- op2_i  in  XLEN  rs2 value.
- reg_w_addr_i  in  REG_ADDR_W  destination register.
- flush_i  in  1  jump/flush from ctrl; cancels the operation in flight.
- stall_o  out  1  to ctrl; holds IF/ID/EX while the unit is working.
- reg_w_ena_o  out  1  one-cycle writeback strobe.
- reg_w_addr_o  out  REG_ADDR_W  captured destination register.
- reg_w_data_o  out  XLEN  result.

Behaviour:
- Reset (arst_n low, asynchronous): state IDLE, counter 0, all datapath registers 0. Outputs reg_w_ena_o, reg_w_addr_o, reg_w_data_o and stall_o are all 0.
- States: IDLE, CALC, DONE.
- IDLE, start_i=1, flush_i=0:
  - Latch op, reg_w_addr and the operand magnitudes.
  - A signed operand is one that is signed for the op: MULH both, MULHSU op1 only, DIV/REM both. Each signed operand is stored as its absolute value and its sign is recorded.
  - Special cases go directly to DONE: divisor==0, and signed overflow (op1=min negative, op2=-1, DIV/REM only).
  - All other cases go to CALC with counter=0.
- IDLE, start_i=1, flush_i=1: flush wins; nothing is latched; stay IDLE.
- CALC, one iteration per cycle, XLEN cycles total; counter counts 0..XLEN-1; move to DONE when counter==XLEN-1.
  - Multiply: radix-2 shift-add into a 2*XLEN product register.
  - Divide: restoring, one quotient bit per cycle; quotient and remainder are XLEN bits.
- DONE (exactly one cycle): reg_w_ena_o=1, reg_w_data_o valid, then return to IDLE.
- Result selection:
  - MUL: low XLEN bits of the product. MULH/MULHSU/MULHU: high XLEN bits.
  - Signed product is negated (2*XLEN two's complement) when the operand signs differ.
  - Quotient is negated when the signs differ; remainder takes the sign of the dividend.
  - Divide by zero: quotient = all ones; remainder = op1 unchanged.
  - Overflow: quotient = op1 (min negative); remainder = 0.
- stall_o: combinational. Equals 1 when (IDLE and start_i and !flush_i) or state==CALC. Equals 0 in DONE, so the pipeline advances in the same cycle the result writes back.
- Latency from the start cycle to reg_w_ena_o: normal ops XLEN+1 cycles; special cases 1 cycle.
- start_i while in CALC or DONE is ignored; ctrl is already stalling, so start_i holds the same instruction.
- flush_i in CALC or DONE: next state IDLE, no writeback. In DONE, reg_w_ena_o is forced to 0 in that same cycle.
- reg_w_ena_o and reg_w_data_o are registered; reg_w_data_o holds its last value while idle.
- Reset asserted mid-operation: immediate return to the reset state; the operation is lost.

Test Plan:
- MUL 7×(-3), XLEN=32 -> stall_o high for 33 cycles; reg_w_data_o=0xFFFFFFEB with reg_w_ena_o=1 for exactly one cycle at start+33.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. All with latency 33.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000. Each with latency 1 and stall_o high only in the start cycle.
- flush_i pulsed at CALC cycle 10 of a DIV -> no reg_w_ena_o; state IDLE next cycle. A start_i in the following cycle is accepted normally. flush_i together with start_i in IDLE -> no stall, no writeback.
- arst_n pulsed low mid-CALC -> all outputs 0 immediately. With XLEN=64: MUL 0x1_0000_0000×0x1_0000_0000 -> 0 low, MULHU -> 1, latency 65.
